debug_trace_buffer: RTL
=======================

Name: debug_trace_buffer

Overview:
- Debug stage between the pipelined processor and the two-4-digit seven-segment display driver on the board top level.
- Captures each distinct (X, Y) value pair the processor exports into a circular history buffer.
- Drives the display with the newest pair (LIVE mode), or lets the user step back through history with two push-buttons (BROWSE mode).

Parameters:
- DEPTH, 16, history entries; power of two, minimum 2.
- DISP_W, 16, bits of X and Y stored and displayed (low bits of each 32-bit input).
- DEBOUNCE_CYCLES, 1000000, clock cycles a raw button level must stay stable before it is accepted (10 ms at 100 MHz).

Ports:
- Clk  in  1  system clock, single clock domain.
- Reset  in  1  asynchronous, active-high reset.
- cpu_x  in  32  processor debug value X (e.g. PC); only [DISP_W-1:0] is used.
- cpu_y  in  32  processor debug value Y (e.g. write-back data); only [DISP_W-1:0] is used.
- sample_en  in  1  processor-advance strobe; inputs are eligible for capture only when high.
- btn_prev  in  1  raw asynchronous button, step to older entry.
- btn_next  in  1  raw asynchronous button, step to newer entry or return to LIVE.
- disp_x  out  DISP_W  value shown on the right display half.
- disp_y  out  DISP_W  value shown on the left display half.
- browse_mode  out  1  high in BROWSE.
- entry_count  out  $clog2(DEPTH)+1  valid entries, saturating at DEPTH.
- view_age  out  $clog2(DEPTH)  distance of the displayed entry from the newest; 0 in LIVE.

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; wr_ptr=0, rd_idx=0, count=0; state LIVE. Buffer RAM is not cleared. Reset mid-browse discards the history.
- Capture: in a cycle where sample_en=1 and (count==0 or the pair {cpu_x,cpu_y}[DISP_W-1:0] differs from the newest stored pair):
  - write the pair at wr_ptr;
  - wr_ptr+1 mod DEPTH;
  - count+1, saturating at DEPTH;
  - when full, the write overwrites the oldest entry.
- Capture runs in both states.
- Identical consecutive pairs are never stored twice.
- Indexing: newest=(wr_ptr-1) mod DEPTH; oldest=(wr_ptr-count) mod DEPTH.
- Buttons: each passes through a button_debounce instance that emits a one-cycle pulse (prev_p / next_p) on an accepted press (rising edge).
- FSM:
  - LIVE:
    - prev_p with count>=2 -> BROWSE, rd_idx=newest-1.
    - prev_p with count<2: ignored.
    - next_p: ignored.
  - BROWSE:
    - prev_p: rd_idx-1 if rd_idx!=oldest; otherwise hold.
    - next_p: if rd_idx+1==newest -> LIVE; otherwise rd_idx+1.
- Simultaneous prev_p and next_p in the same cycle: both ignored.
- Overwrite protection: in BROWSE, if a capture with count==DEPTH writes the slot at rd_idx, rd_idx advances by 1 (tracks the oldest entry).
  - This bump takes priority; a prev_p in the same cycle is ignored.
  - A next_p in the same cycle applies after the bump.
- Outputs are registered with 1-cycle latency:
  - disp_x/disp_y = entry at newest (LIVE, or 0 if count==0) or at rd_idx (BROWSE);
  - view_age = (newest-rd_idx) mod DEPTH in BROWSE;
  - in LIVE, a captured pair appears on the outputs 2 cycles after the sample_en cycle (write, then read register).
- Buffer is inferred as distributed RAM or a register array: one write port, one read port.

Decomposition:
- Shared package: state encoding constants (ST_LIVE=1'b0, ST_BROWSE=1'b1) and the pointer-width function/localparam derived from DEPTH.
- Sub-module button_debounce, instantiated twice.
  - Two-flop synchronizer, stability counter up to DEBOUNCE_CYCLES, one-cycle rising-edge pulse output.
  - Same Clk and asynchronous active-high Reset.

Test Plan (DEBOUNCE_CYCLES=4, DEPTH=4):
- Reset mid-operation: assert Reset asynchronously -> all outputs 0 within the same timestep; count=0, browse_mode=0.
- Capture and dedup: sample_en with pairs (0x0004,0x0011), (0x0004,0x0011), (0x0008,0x0022) -> entry_count=2; disp_x=0x0008, disp_y=0x0022 two cycles after the last sample.
- Wrap-around: capture 6 distinct pairs 1..6 -> entry_count=4; browsing oldest shows pair 3; further prev_p holds at pair 3, view_age=3.
- Browse navigation: from LIVE with pairs 1..4, pulse prev twice -> disp shows pair 2, view_age=2. Pulse next twice -> LIVE showing pair 4, browse_mode=0.
- Debounce: btn_prev glitch high for 2 cycles -> no state change. Held 10 cycles -> exactly one step. Both buttons pressed together -> no change.
- Overwrite during browse: full buffer, rd_idx at oldest (pair 1), new capture of pair 5 -> display shifts to pair 2, browse_mode stays 1.

Source files
------------

// File: rtl/debug_trace_buffer_pkg.sv
// Shared definitions for the debug trace buffer: FSM state encoding and
// pointer-width helper derived from the history depth.
package debug_trace_buffer_pkg;

  typedef enum logic {
    ST_LIVE   = 1'b0,
    ST_BROWSE = 1'b1
  } state_e;

  localparam int unsigned DEPTH_DEFAULT = 16;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int unsigned PTR_W_DEFAULT = ptr_width(DEPTH_DEFAULT);

endpackage

// File: rtl/debug_trace_buffer_button.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted rising edge.
module button_debounce #(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // A new level is accepted only after it differs from the stable level for CYCLES cycles
  always_comb begin
    sync_d   = {sync_q[0], btn_i};
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        stable_d = sync_q[1];
        pulse_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/debug_trace_buffer.sv
// Captures distinct (X, Y) debug pairs into a circular history and shows
// either the newest pair (LIVE) or a user-selected older one (BROWSE).
module debug_trace_buffer
  import debug_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned DISP_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [31:0]                   cpu_x,
  input  logic [31:0]                   cpu_y,
  input  logic                          sample_en,
  input  logic                          btn_prev,
  input  logic                          btn_next,
  output logic [DISP_W-1:0]             disp_x,
  output logic [DISP_W-1:0]             disp_y,
  output logic                          browse_mode,
  output logic [ptr_width(DEPTH):0]     entry_count,
  output logic [ptr_width(DEPTH)-1:0]   view_age
);

  localparam int unsigned PTR_W  = ptr_width(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PAIR_W = 2 * DISP_W;

  logic prev_p, next_p;

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_i   (btn_prev),
    .pulse_o (prev_p)
  );

  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .Clk     (Clk),
    .Reset   (Reset),
    .btn_i   (btn_next),
    .pulse_o (next_p)
  );

  generate
    if (DISP_W < 32) begin : g_unused_hi
      logic unused_hi_c;
      assign unused_hi_c = ^{cpu_x[31:DISP_W], cpu_y[31:DISP_W]};
    end
  endgenerate

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PAIR_W-1:0]  last_q, last_d;
  logic [PAIR_W-1:0]  mem_q [DEPTH];

  logic [DISP_W-1:0]  disp_x_q, disp_x_d;
  logic [DISP_W-1:0]  disp_y_q, disp_y_d;
  logic               browse_q, browse_d;
  logic [CNT_W-1:0]   entry_count_q, entry_count_d;
  logic [PTR_W-1:0]   view_age_q, view_age_d;

  logic [PAIR_W-1:0]  new_pair_c;
  logic [PTR_W-1:0]   newest_c, oldest_c, rd_addr_c, rd_base_c;
  logic [PAIR_W-1:0]  rd_pair_c;
  logic               full_c, capture_c, bump_c, prev_ok_c, next_ok_c;

  // Dedup compares against a copy of the newest pair so the RAM keeps a single read port
  always_comb begin
    new_pair_c = {cpu_x[DISP_W-1:0], cpu_y[DISP_W-1:0]};
    newest_c   = wr_ptr_q - PTR_W'(1);
    oldest_c   = wr_ptr_q - count_q[PTR_W-1:0];
    full_c     = (count_q == CNT_W'(DEPTH));
    capture_c  = sample_en && ((count_q == '0) || (new_pair_c != last_q));
    bump_c     = (state_q == ST_BROWSE) && capture_c && full_c && (wr_ptr_q == rd_idx_q);
    prev_ok_c  = prev_p && !next_p;
    next_ok_c  = next_p && !prev_p;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (capture_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      last_d   = new_pair_c;
      if (!full_c) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Navigation FSM; an overwrite bump wins over prev, next steps from the bumped index
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_base_c = bump_c ? (rd_idx_q + PTR_W'(1)) : rd_idx_q;
    unique case (state_q)
      ST_LIVE: begin
        if (prev_ok_c && (count_q >= CNT_W'(2))) begin
          state_d  = ST_BROWSE;
          rd_idx_d = newest_c - PTR_W'(1);
        end
      end
      ST_BROWSE: begin
        rd_idx_d = rd_base_c;
        if (next_ok_c) begin
          if ((rd_base_c + PTR_W'(1)) == newest_c) begin
            state_d = ST_LIVE;
          end else begin
            rd_idx_d = rd_base_c + PTR_W'(1);
          end
        end else if (prev_ok_c && !bump_c && (rd_idx_q != oldest_c)) begin
          rd_idx_d = rd_idx_q - PTR_W'(1);
        end
      end
      default: state_d = ST_LIVE;
    endcase
  end

  always_comb begin
    rd_addr_c     = (state_q == ST_BROWSE) ? rd_idx_q : newest_c;
    rd_pair_c     = mem_q[rd_addr_c];
    disp_x_d      = rd_pair_c[PAIR_W-1:DISP_W];
    disp_y_d      = rd_pair_c[DISP_W-1:0];
    browse_d      = (state_q == ST_BROWSE);
    entry_count_d = count_q;
    view_age_d    = '0;
    if (state_q == ST_BROWSE) begin
      view_age_d = newest_c - rd_idx_q;
    end else if (count_q == '0) begin
      disp_x_d = '0;
      disp_y_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (capture_c) begin
      mem_q[wr_ptr_q] <= new_pair_c;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_LIVE;
      wr_ptr_q      <= '0;
      rd_idx_q      <= '0;
      count_q       <= '0;
      last_q        <= '0;
      disp_x_q      <= '0;
      disp_y_q      <= '0;
      browse_q      <= 1'b0;
      entry_count_q <= '0;
      view_age_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_idx_q      <= rd_idx_d;
      count_q       <= count_d;
      last_q        <= last_d;
      disp_x_q      <= disp_x_d;
      disp_y_q      <= disp_y_d;
      browse_q      <= browse_d;
      entry_count_q <= entry_count_d;
      view_age_q    <= view_age_d;
    end
  end

  assign disp_x      = disp_x_q;
  assign disp_y      = disp_y_q;
  assign browse_mode = browse_q;
  assign entry_count = entry_count_q;
  assign view_age    = view_age_q;

endmodule
